// File: rtl/conv_sa_sum_ctrl_pkg.sv
// Shared types and constants for the Conv_sa_sum chain sequencer.
// Memory geometry, write latency, FSM states and delay-line entry.
package conv_sa_sum_ctrl_pkg;

    localparam int SUM_DEPTH  = 8;
    localparam int SUM_AW     = 3;
    localparam int SUM_WR_LAT = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_e;

    typedef struct packed {
        logic              vld;
        logic              last;
        logic [SUM_AW-1:0] addr;
    } dly_ent_t;

    // Last slot index of a round: clamps oversize counts to the
    // memory depth and treats 0 as 1 (the zero case never issues).
    function automatic logic [SUM_AW-1:0] slot_last(
        input logic [3:0] n,
        input logic [3:0] nmax
    );
        logic [3:0] c;
        c = (n > nmax) ? nmax : n;
        if (c == 4'd0) c = 4'd1;
        return SUM_AW'(c - 4'd1);
    endfunction

endpackage

// File: rtl/conv_sa_sum_ctrl_dly.sv
// Write-side delay line: carries {vld, last, addr} from issue
// to the sum-unit write port, plus a registered final-sum strobe.
module conv_sa_sum_ctrl_dly
    import conv_sa_sum_ctrl_pkg::*;
#(
    parameter int WR_LAT = SUM_WR_LAT
) (
    input  logic                    clk_i,
    input  logic                    rstn_i,
    input  dly_ent_t                ent_i,
    output dly_ent_t [WR_LAT-1:0]   stage_o,
    output logic                    sum_vld_o
);

    dly_ent_t [WR_LAT-1:0] stg_q;
    dly_ent_t [WR_LAT-1:0] stg_d;
    logic                  sum_vld_q;

    // Shift the new entry in at stage 0, everything else moves on.
    always_comb begin
        stg_d    = '0;
        stg_d[0] = ent_i;
        for (int i = 1; i < WR_LAT; i++) begin
            stg_d[i] = stg_q[i-1];
        end
    end

    // Stage registers and final-sum strobe, cleared on reset.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            stg_q     <= '0;
            sum_vld_q <= 1'b0;
        end else begin
            stg_q     <= stg_d;
            sum_vld_q <= stg_d[WR_LAT-1].vld & stg_d[WR_LAT-1].last;
        end
    end

    assign stage_o   = stg_q;
    assign sum_vld_o = sum_vld_q;

endmodule

// File: rtl/conv_sa_sum_ctrl.sv
// Slot/round sequencer driving the head of one Conv_sa_sum chain.
// Issues prefetches, spaces reuse of a slot past its write, drains.
module conv_sa_sum_ctrl
    import conv_sa_sum_ctrl_pkg::*;
#(
    parameter int N_SLOT_MAX = SUM_DEPTH,
    parameter int WR_LAT     = SUM_WR_LAT,
    parameter int RND_W      = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [RND_W-1:0]  cfg_n_rnd,
    input  logic [3:0]        cfg_n_slot,
    input  logic              stall,
    output logic              pe_issue,
    output logic [SUM_AW-1:0] pe_slot,
    output logic [SUM_AW-1:0] psum_prefetch_addr,
    output logic              psum_vld,
    output logic              psum_last_rnd,
    output logic [SUM_AW-1:0] psum_wr_addr,
    output logic              sum_vld,
    output logic              busy,
    output logic              done
);

    state_e              state_q;
    logic [SUM_AW-1:0]   slot_q;
    logic [SUM_AW-1:0]   slot_last_q;
    logic [RND_W-1:0]    rnd_q;
    logic [RND_W-1:0]    rnd_last_q;
    logic                pe_issue_q;
    logic [SUM_AW-1:0]   pe_slot_q;
    logic                last_q;
    logic [SUM_AW-1:0]   pf_q;
    logic                busy_q;
    logic                done_q;

    dly_ent_t              ent;
    dly_ent_t [WR_LAT-1:0] stg;
    logic                  hazard;
    logic                  dly_busy;
    logic                  can_issue;

    // Slot reuse is blocked while an earlier write to it is still
    // ahead of the read port: issued last cycle or in early stages.
    always_comb begin
        hazard = pe_issue_q && (pe_slot_q == slot_q);
        for (int i = 0; i < WR_LAT - 1; i++) begin
            if (stg[i].vld && (stg[i].addr == slot_q)) hazard = 1'b1;
        end
    end

    // Anything still in flight toward the write port.
    always_comb begin
        dly_busy = pe_issue_q;
        for (int i = 0; i < WR_LAT; i++) begin
            if (stg[i].vld) dly_busy = 1'b1;
        end
    end

    assign can_issue = !stall && !hazard;

    assign ent.vld  = pe_issue_q;
    assign ent.last = last_q;
    assign ent.addr = pe_slot_q;

    // Control FSM with registered issue, prefetch and status outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            slot_q      <= '0;
            slot_last_q <= '0;
            rnd_q       <= '0;
            rnd_last_q  <= '0;
            pe_issue_q  <= 1'b0;
            pe_slot_q   <= '0;
            last_q      <= 1'b0;
            pf_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            pe_issue_q <= 1'b0;
            last_q     <= 1'b0;
            done_q     <= 1'b0;
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        slot_q      <= '0;
                        rnd_q       <= '0;
                        slot_last_q <= slot_last(cfg_n_slot, 4'(N_SLOT_MAX));
                        rnd_last_q  <= cfg_n_rnd - 1'b1;
                        if (cfg_n_rnd == '0 || cfg_n_slot == 4'd0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_RUN;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (can_issue) begin
                        pe_issue_q <= 1'b1;
                        pe_slot_q  <= slot_q;
                        pf_q       <= slot_q;
                        last_q     <= (rnd_q == rnd_last_q);
                        if (slot_q == slot_last_q) begin
                            slot_q <= '0;
                            rnd_q  <= rnd_q + 1'b1;
                            if (rnd_q == rnd_last_q) state_q <= ST_DRAIN;
                        end else begin
                            slot_q <= slot_q + 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (!dly_busy) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    conv_sa_sum_ctrl_dly #(
        .WR_LAT (WR_LAT)
    ) u_dly (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .ent_i     (ent),
        .stage_o   (stg),
        .sum_vld_o (sum_vld)
    );

    assign pe_issue           = pe_issue_q;
    assign pe_slot            = pe_slot_q;
    assign psum_prefetch_addr = pf_q;
    assign psum_vld           = stg[WR_LAT-1].vld;
    assign psum_last_rnd      = stg[WR_LAT-1].last;
    assign psum_wr_addr       = stg[WR_LAT-1].addr;
    assign busy               = busy_q;
    assign done               = done_q;

endmodule
